pic_inta_sequencer: RTL and testbench

- Synchronous interrupt-acknowledge controller for the 8259A PIC, 8086 mode.
- Sits between the priority resolver, the IRR/ISR storage and the CPU INTA pin.
- Turns the resolver's INT request into the two-pulse INTA handshake: freezes the resolver, sets and owns the ISR bits, clears the IRR bit, and drives the vector byte.
- Executes EOI commands (non-specific, specific, automatic) and maintains the rotating zero-level priority base.

---
 rtl/pic_inta_sequencer.sv | 156 +++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// 8259A interrupt-acknowledge sequencer (8086 mode): runs the two-pulse INTA
// handshake, owns the ISR, executes EOI commands and tracks the rotating priority base.
module pic_inta_sequencer #(
  parameter int unsigned          VEC_IDX_W    = 3,
  parameter logic [VEC_IDX_W-1:0] SPURIOUS_IDX = 3'd7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 int_req,
  input  logic [VEC_IDX_W-1:0] req_index,
  input  logic [7:0]           irr,
  input  logic                 inta_n,
  input  logic [4:0]           icw2_base,
  input  logic                 aeoi_mode,
  input  logic                 rotate_mode,
  input  logic                 eoi_valid,
  input  logic                 eoi_specific,
  input  logic [VEC_IDX_W-1:0] eoi_level,
  output logic                 int_out,
  output logic                 freezing,
  output logic [7:0]           isr,
  output logic                 irr_clr,
  output logic [VEC_IDX_W-1:0] irr_clr_idx,
  output logic [7:0]           data_out,
  output logic                 data_oe,
  output logic [VEC_IDX_W-1:0] priority_base,
  output logic                 eoi_done,
  output logic [VEC_IDX_W-1:0] eoi_idx
);

  localparam int unsigned    LEVELS = 1 << VEC_IDX_W;
  localparam logic [LEVELS-1:0] BIT0 = LEVELS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_ACK1,
    S_WAIT2,
    S_ACK2
  } state_t;

  state_t               state_q, state_d;
  logic                 inta_prev_q;
  logic                 inta_fall, inta_rise;
  logic [VEC_IDX_W-1:0] idx_q, idx_d;
  logic                 spur_q, spur_d;

  logic                 ack_start, req_valid;
  logic [LEVELS-1:0]    set_mask, auto_mask, strobe_mask;
  logic [LEVELS-1:0]    isr_rem, isr_d;
  logic                 aeoi_fire;
  logic [VEC_IDX_W-1:0] scan_pos, ns_idx, eoi_target;
  logic                 ns_hit, strobe_hit;
  logic                 irr_clr_d, eoi_done_d;
  logic [VEC_IDX_W-1:0] irr_clr_idx_d, eoi_idx_d, priority_base_d;
  logic [7:0]           data_out_d;

  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      inta_prev_q   <= 1'b1;
      idx_q         <= '0;
      spur_q        <= 1'b0;
      isr           <= '0;
      irr_clr       <= 1'b0;
      irr_clr_idx   <= '0;
      data_out      <= '0;
      priority_base <= '0;
      eoi_done      <= 1'b0;
      eoi_idx       <= '0;
    end else begin
      state_q       <= state_d;
      inta_prev_q   <= inta_n;
      idx_q         <= idx_d;
      spur_q        <= spur_d;
      isr           <= isr_d;
      irr_clr       <= irr_clr_d;
      irr_clr_idx   <= irr_clr_idx_d;
      data_out      <= data_out_d;
      priority_base <= priority_base_d;
      eoi_done      <= eoi_done_d;
      eoi_idx       <= eoi_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (int_req) state_d = S_PEND;
      S_PEND: begin
        if (inta_fall)     state_d = S_ACK1;
        else if (!int_req) state_d = S_IDLE;
      end
      S_ACK1:  if (inta_rise) state_d = S_WAIT2;
      S_WAIT2: if (inta_fall) state_d = S_ACK2;
      S_ACK2:  if (inta_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_out  = (state_q == S_PEND);
    freezing = (state_q == S_ACK1) || (state_q == S_WAIT2) || (state_q == S_ACK2);
    data_oe  = (state_q == S_ACK2);

    ack_start = (state_q == S_PEND) && inta_fall;
    req_valid = int_req && irr[req_index];

    idx_d  = idx_q;
    spur_d = spur_q;
    if (ack_start) begin
      idx_d  = req_valid ? req_index : SPURIOUS_IDX;
      spur_d = !req_valid;
    end

    set_mask      = (ack_start && req_valid) ? (BIT0 << req_index) : '0;
    irr_clr_d     = ack_start && req_valid;
    irr_clr_idx_d = irr_clr_d ? req_index : irr_clr_idx;

    data_out_d = ((state_q == S_WAIT2) && inta_fall) ? {icw2_base, idx_q} : data_out;

    // Automatic EOI is applied first; a same-cycle EOI strobe then sees the remaining ISR.
    aeoi_fire = (state_q == S_ACK2) && inta_rise && aeoi_mode && !spur_q && isr[idx_q];
    auto_mask = aeoi_fire ? (BIT0 << idx_q) : '0;
    isr_rem   = isr & ~auto_mask;

    ns_hit   = 1'b0;
    ns_idx   = '0;
    scan_pos = '0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      scan_pos = priority_base + VEC_IDX_W'(i);
      if (!ns_hit && isr_rem[scan_pos]) begin
        ns_hit = 1'b1;
        ns_idx = scan_pos;
      end
    end

    eoi_target  = eoi_specific ? eoi_level : ns_idx;
    strobe_hit  = eoi_valid && (eoi_specific ? isr_rem[eoi_level] : ns_hit);
    strobe_mask = strobe_hit ? (BIT0 << eoi_target) : '0;

    // Set is OR-ed last so an acknowledge beats an EOI aimed at the same level.
    isr_d = (isr_rem & ~strobe_mask) | set_mask;

    eoi_done_d = aeoi_fire || strobe_hit;
    if (aeoi_fire)       eoi_idx_d = idx_q;
    else if (strobe_hit) eoi_idx_d = eoi_target;
    else                 eoi_idx_d = eoi_idx;

    priority_base_d = (eoi_done_d && rotate_mode) ? eoi_idx_d + VEC_IDX_W'(1) : priority_base;
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: directed scenarios plus randomized
// INTA/EOI traffic compared every cycle against a behavioural model.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       int_req;
  logic [2:0] req_index;
  logic [7:0] irr;
  logic       inta_n;
  logic [4:0] icw2_base;
  logic       aeoi_mode, rotate_mode;
  logic       eoi_valid, eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out, freezing, irr_clr, data_oe, eoi_done;
  logic [7:0] isr, data_out;
  logic [2:0] irr_clr_idx, priority_base, eoi_idx;

  always #5 clk = ~clk;

  pic_inta_sequencer #(.VEC_IDX_W(3), .SPURIOUS_IDX(3'd7)) dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .req_index(req_index), .irr(irr),
    .inta_n(inta_n), .icw2_base(icw2_base), .aeoi_mode(aeoi_mode),
    .rotate_mode(rotate_mode), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .int_out(int_out), .freezing(freezing), .isr(isr),
    .irr_clr(irr_clr), .irr_clr_idx(irr_clr_idx), .data_out(data_out),
    .data_oe(data_oe), .priority_base(priority_base), .eoi_done(eoi_done),
    .eoi_idx(eoi_idx)
  );

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: a handshake is "active" from the request until the
  // fourth INTA edge (fall, rise, fall, rise); m_edges counts edges seen.
  bit         m_active, m_prev, m_spur;
  int         m_edges, m_idx, m_base, m_eoi_idx, m_clr_idx;
  logic [7:0] m_isr, m_dout;
  bit         m_int, m_frz, m_doe, m_clr, m_done;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 0; m_prev = 1; m_spur = 0; m_edges = 0; m_idx = 0; m_base = 0;
    m_eoi_idx = 0; m_clr_idx = 0; m_isr = 8'h00; m_dout = 8'h00;
    m_int = 0; m_frz = 0; m_doe = 0; m_clr = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit fall, rise;
    int set_bit, auto_bit, done_idx, tgt, p;
    logic [7:0] w;
    fall = m_prev && !inta_n;
    rise = !m_prev && inta_n;
    m_prev = inta_n;
    set_bit = -1; auto_bit = -1; done_idx = -1;
    m_clr = 0; m_done = 0;
    if (!m_active) begin
      if (int_req) begin m_active = 1; m_edges = 0; m_int = 1; end
    end else begin
      case (m_edges)
        0: if (fall) begin
             m_edges = 1; m_frz = 1; m_int = 0;
             m_spur = !(int_req && irr[req_index]);
             m_idx = m_spur ? 7 : int'(req_index);
             if (!m_spur) begin set_bit = m_idx; m_clr = 1; m_clr_idx = m_idx; end
           end else if (!int_req) begin
             m_active = 0; m_int = 0;
           end
        1: if (rise) m_edges = 2;
        2: if (fall) begin m_edges = 3; m_dout = {icw2_base, 3'(m_idx)}; m_doe = 1; end
        default: if (rise) begin
             m_doe = 0; m_frz = 0; m_active = 0;
             if (aeoi_mode && !m_spur) auto_bit = m_idx;
           end
      endcase
    end
    w = m_isr;
    if (auto_bit >= 0 && w[auto_bit]) begin w[auto_bit] = 1'b0; done_idx = auto_bit; end
    if (eoi_valid) begin
      tgt = -1;
      if (eoi_specific) begin
        if (w[eoi_level]) tgt = int'(eoi_level);
      end else begin
        for (int j = 0; j < 8; j++) begin
          p = (m_base + j) % 8;
          if (tgt < 0 && w[p]) tgt = p;
        end
      end
      if (tgt >= 0) begin w[tgt] = 1'b0; if (done_idx < 0) done_idx = tgt; end
    end
    if (set_bit >= 0) w[set_bit] = 1'b1;
    m_isr = w;
    if (done_idx >= 0) begin
      m_done = 1; m_eoi_idx = done_idx;
      if (rotate_mode) m_base = (done_idx + 1) % 8;
    end
  endtask

  task automatic compare_all();
    chk("int_out",       {7'd0, int_out},       {7'd0, m_int});
    chk("freezing",      {7'd0, freezing},      {7'd0, m_frz});
    chk("isr",           isr,                   m_isr);
    chk("irr_clr",       {7'd0, irr_clr},       {7'd0, m_clr});
    chk("irr_clr_idx",   {5'd0, irr_clr_idx},   8'(m_clr_idx));
    chk("data_out",      data_out,              m_dout);
    chk("data_oe",       {7'd0, data_oe},       {7'd0, m_doe});
    chk("priority_base", {5'd0, priority_base}, 8'(m_base));
    chk("eoi_done",      {7'd0, eoi_done},      {7'd0, m_done});
    chk("eoi_idx",       {5'd0, eoi_idx},       8'(m_eoi_idx));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rst_n = 1'b1;
  endtask

  task automatic run_ack();
    cycle();
    inta_n = 1'b0; cycle();
    int_req = 1'b0; irr = 8'h00; cycle();
    inta_n = 1'b1; cycle(); cycle();
    inta_n = 1'b0; cycle(); cycle();
    inta_n = 1'b1; cycle();
  endtask

  initial begin
    rst_n = 1'b0; int_req = 0; req_index = 0; irr = 0; inta_n = 1; icw2_base = 5'h10;
    aeoi_mode = 0; rotate_mode = 0; eoi_valid = 0; eoi_specific = 0; eoi_level = 0;
    model_reset();
    @(negedge clk);
    chk("reset_isr", isr, 8'h00);
    chk("reset_int_out", {7'd0, int_out}, 8'h00);
    rst_n = 1'b1;
    cycle();

    // Basic acknowledge of level 3
    int_req = 1; req_index = 3; irr = 8'h08;
    cycle();
    chk("t1_int_out_hi", {7'd0, int_out}, 8'h01);
    inta_n = 0; cycle();
    chk("t1_irr_clr", {7'd0, irr_clr}, 8'h01);
    chk("t1_irr_clr_idx", {5'd0, irr_clr_idx}, 8'h03);
    chk("t1_int_out_lo", {7'd0, int_out}, 8'h00);
    chk("t1_isr", isr, 8'h08);
    chk("t1_model_isr", m_isr, 8'h08);
    int_req = 0; irr = 0; cycle();
    chk("t1_irr_clr_pulse", {7'd0, irr_clr}, 8'h00);
    inta_n = 1; cycle(); cycle();
    chk("t1_oe_gap", {7'd0, data_oe}, 8'h00);
    chk("t1_frz_gap", {7'd0, freezing}, 8'h01);
    inta_n = 0; cycle();
    chk("t1_data_out", data_out, 8'h83);
    chk("t1_model_dout", m_dout, 8'h83);
    chk("t1_data_oe", {7'd0, data_oe}, 8'h01);
    cycle();
    inta_n = 1; cycle();
    chk("t1_oe_end", {7'd0, data_oe}, 8'h00);
    chk("t1_frz_end", {7'd0, freezing}, 8'h00);
    cycle();
    eoi_valid = 1; eoi_specific = 1; eoi_level = 3; cycle();
    eoi_valid = 0;
    chk("t1_seoi_done", {7'd0, eoi_done}, 8'h01);
    chk("t1_seoi_isr", isr, 8'h00);
    cycle();

    // Automatic EOI with rotation on level 5
    aeoi_mode = 1; rotate_mode = 1; int_req = 1; req_index = 5; irr = 8'h20;
    run_ack();
    chk("t2_isr", isr, 8'h00);
    chk("t2_eoi_done", {7'd0, eoi_done}, 8'h01);
    chk("t2_eoi_idx", {5'd0, eoi_idx}, 8'h05);
    chk("t2_base", {5'd0, priority_base}, 8'h06);
    chk("t2_model_base", 8'(m_base), 8'h06);
    cycle();

    // Non-specific EOI under rotation, ISR = 8'h81, base = 6
    aeoi_mode = 0; rotate_mode = 0;
    int_req = 1; req_index = 7; irr = 8'h80; run_ack();
    int_req = 1; req_index = 0; irr = 8'h01; run_ack();
    chk("t3_isr", isr, 8'h81);
    rotate_mode = 1; eoi_valid = 1; eoi_specific = 0; cycle();
    chk("t3_isr1", isr, 8'h01);
    chk("t3_base1", {5'd0, priority_base}, 8'h00);
    cycle();
    eoi_valid = 0;
    chk("t3_isr2", isr, 8'h00);
    chk("t3_base2", {5'd0, priority_base}, 8'h01);
    cycle();

    // Request withdrawn before the first INTA, then a stray INTA in idle
    rotate_mode = 0; int_req = 1; req_index = 2; irr = 8'h04; cycle();
    int_req = 0; cycle();
    chk("t4_drop_int", {7'd0, int_out}, 8'h00);
    inta_n = 0; cycle();
    chk("t4_stray_frz", {7'd0, freezing}, 8'h00);
    inta_n = 1; cycle();

    // Request withdrawn at the first INTA fall: spurious vector 7
    int_req = 1; cycle();
    int_req = 0; inta_n = 0; cycle();
    chk("t4_spur_clr", {7'd0, irr_clr}, 8'h00);
    chk("t4_spur_frz", {7'd0, freezing}, 8'h01);
    inta_n = 1; cycle(); cycle();
    inta_n = 0; cycle();
    chk("t4_spur_vec", data_out, 8'h87);
    cycle(); inta_n = 1; cycle();
    chk("t4_spur_isr", isr, 8'h00);

    // Specific EOI on a level that is not in service
    int_req = 1; req_index = 2; irr = 8'h04; run_ack();
    eoi_valid = 1; eoi_specific = 1; eoi_level = 1; cycle();
    eoi_valid = 0;
    chk("t5_isr", isr, 8'h04);
    chk("t5_no_done", {7'd0, eoi_done}, 8'h00);
    chk("t5_base", {5'd0, priority_base}, 8'h01);

    // Reset in the gap between the two INTA pulses
    int_req = 1; req_index = 4; irr = 8'h10; cycle();
    inta_n = 0; cycle();
    int_req = 0; irr = 0; inta_n = 1; cycle();
    do_reset();
    chk("t6_rst_isr", isr, 8'h00);
    chk("t6_rst_frz", {7'd0, freezing}, 8'h00);
    chk("t6_rst_base", {5'd0, priority_base}, 8'h00);
    inta_n = 0; cycle(); cycle();
    chk("t6_post_oe", {7'd0, data_oe}, 8'h00);
    chk("t6_post_out", data_out, 8'h00);
    inta_n = 1; cycle();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) begin
        int_req = ~int_req;
        if (int_req) req_index = 3'($urandom_range(7));
      end else if ($urandom_range(15) == 0) begin
        req_index = 3'($urandom_range(7));
      end
      irr = 8'($urandom_range(255));
      if ($urandom_range(3) != 0) irr[req_index] = 1'b1;
      if ($urandom_range(2) == 0) inta_n = ~inta_n;
      eoi_valid = ($urandom_range(9) == 0);
      eoi_specific = 1'($urandom_range(1));
      eoi_level = 3'($urandom_range(7));
      if ($urandom_range(49) == 0) aeoi_mode = 1'($urandom_range(1));
      if ($urandom_range(49) == 0) rotate_mode = 1'($urandom_range(1));
      if ($urandom_range(99) == 0) icw2_base = 5'($urandom_range(31));
      if ($urandom_range(499) == 0) do_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
